// File: rtl/chunked_add_sub.sv
// rtl/chunked_add_sub.sv - multi-cycle N-bit adder/subtractor working CHUNK bits per clock
module chunked_add_sub #(
    parameter int N     = 8,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    input  logic         Sub,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Sum,
    output logic         Cout,
    output logic         Ovf
);

    localparam int M  = N / CHUNK;
    localparam int IW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;        // B already inverted for subtraction
    logic [N-1:0]   psum_q, psum_d;  // slice results accumulate here, hidden from Sum
    logic [N-1:0]   sum_q, sum_d;
    logic           carry_q, carry_d;
    logic           cout_q, cout_d;
    logic           ovf_q, ovf_d;
    logic [IW-1:0]  idx_q, idx_d;

    logic [CHUNK-1:0] a_slice, b_slice, s_slice;
    logic             c_slice;

    // One CHUNK-wide ripple stage fed by the current slice index
    always_comb begin
        a_slice = a_q[idx_q*CHUNK +: CHUNK];
        b_slice = b_q[idx_q*CHUNK +: CHUNK];
        {c_slice, s_slice} = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_q};
    end

    // Next-state and datapath update; subtraction is A + ~B + ~Cin
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = Sub ? ~B : B;
                    carry_d = Sub ? ~Cin : Cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                psum_d[idx_q*CHUNK +: CHUNK] = s_slice;
                carry_d = c_slice;
                idx_d   = idx_q + IW'(1);
                if (idx_q == IW'(M - 1)) begin
                    sum_d   = psum_d;
                    cout_d  = c_slice;
                    ovf_d   = (a_q[N-1] == b_q[N-1]) && (psum_d[N-1] != a_q[N-1]);
                    idx_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    assign ready = (state_q == S_IDLE);
    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign Sum   = sum_q;
    assign Cout  = cout_q;
    assign Ovf   = ovf_q;

endmodule
